// File: rtl/rps_referee.sv
// Rock/paper/scissors round referee.
// Collects one locked choice per player, judges the round, shows the result
// code for HOLD_CYCLES cycles, then waits for all buttons to be released
// before re-arming.
// Optional macro RPS_SCORE_EN: adds saturating BCD win counters per player.
module rps_referee #(
    parameter int unsigned HOLD_CYCLES = 24_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] p1_btn,
    input  logic [2:0] p2_btn,
    output logic [2:0] result,
    output logic       p1_locked,
    output logic       p2_locked,
    output logic       round_done,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] RES_IDLE = 3'b100;
    localparam logic [2:0] RES_DRAW = 3'b010;
    localparam logic [2:0] RES_P1   = 3'b000;
    localparam logic [2:0] RES_P2   = 3'b001;

    typedef enum logic [1:0] {
        S_REARM,
        S_COLLECT,
        S_RESULT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_p1_choice;
    logic [2:0]       r_p2_choice;
    logic             r_p1_locked;
    logic             r_p2_locked;
    logic [2:0]       r_result;
    logic [CNT_W-1:0] r_cnt;

    logic             w_p1_onehot;
    logic             w_p2_onehot;
    logic             w_both_locked;
    logic             w_idle_btns;
    logic             w_hold_end;
    logic [2:0]       w_judge;

    assign w_p1_onehot   = (p1_btn == 3'b100) || (p1_btn == 3'b010) || (p1_btn == 3'b001);
    assign w_p2_onehot   = (p2_btn == 3'b100) || (p2_btn == 3'b010) || (p2_btn == 3'b001);
    assign w_both_locked = r_p1_locked && r_p2_locked;
    assign w_idle_btns   = (p1_btn == 3'b000) && (p2_btn == 3'b000);
    assign w_hold_end    = (r_cnt == CNT_W'(HOLD_CYCLES - 1));

    // Judge stored choices: each one-hot choice beats the one obtained by rotating it left.
    always_comb begin
        if (r_p1_choice == r_p2_choice) begin
            w_judge = RES_DRAW;
        end else if (r_p2_choice == {r_p1_choice[1:0], r_p1_choice[2]}) begin
            w_judge = RES_P1;
        end else begin
            w_judge = RES_P2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REARM;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REARM:   if (w_idle_btns) w_next = S_COLLECT;
            S_COLLECT: if (w_both_locked) w_next = S_RESULT;
            S_RESULT:  if (w_hold_end) w_next = S_REARM;
            default:   w_next = S_REARM;
        endcase
    end

    // Choice capture, result latch and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_choice <= '0;
            r_p2_choice <= '0;
            r_p1_locked <= 1'b0;
            r_p2_locked <= 1'b0;
            r_result    <= RES_IDLE;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_REARM: begin
                    r_p1_locked <= 1'b0;
                    r_p2_locked <= 1'b0;
                end
                S_COLLECT: begin
                    if (w_both_locked) begin
                        r_result <= w_judge;
                        r_cnt    <= '0;
                    end else begin
                        if (!r_p1_locked && w_p1_onehot) begin
                            r_p1_choice <= p1_btn;
                            r_p1_locked <= 1'b1;
                        end
                        if (!r_p2_locked && w_p2_onehot) begin
                            r_p2_choice <= p2_btn;
                            r_p2_locked <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_hold_end) begin
                        r_p1_locked <= 1'b0;
                        r_p2_locked <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: the result code is only shown while in RESULT; the counter is
    // zero exactly on the first RESULT cycle, which marks round_done.
    always_comb begin
        result     = (r_state == S_RESULT) ? r_result : RES_IDLE;
        round_done = (r_state == S_RESULT) && (r_cnt == '0);
        p1_locked  = r_p1_locked;
        p2_locked  = r_p2_locked;
    end

`ifdef RPS_SCORE_EN
    logic [3:0] r_p1_score;
    logic [3:0] r_p2_score;

    // Saturating win counters, updated on the edge that loads a result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_score <= '0;
            r_p2_score <= '0;
        end else if ((r_state == S_COLLECT) && w_both_locked) begin
            if ((w_judge == RES_P1) && (r_p1_score != 4'd9)) r_p1_score <= r_p1_score + 4'd1;
            if ((w_judge == RES_P2) && (r_p2_score != 4'd9)) r_p2_score <= r_p2_score + 4'd1;
        end
    end

    assign p1_score = r_p1_score;
    assign p2_score = r_p2_score;
`else
    assign p1_score = '0;
    assign p2_score = '0;
`endif

endmodule

// File: tb/tb_rps_referee.sv
// Self-checking bench for rps_referee (HOLD_CYCLES = 8).
// A round-level model predicts every output after each clock edge; directed
// steps add literal expectations at the interesting points.
module tb_rps_referee;

    localparam int HOLD = 8;

    logic       clk;
    logic       reset;
    logic [2:0] p1_btn;
    logic [2:0] p2_btn;
    logic [2:0] result;
    logic       p1_locked;
    logic       p2_locked;
    logic       round_done;
    logic [3:0] p1_score;
    logic [3:0] p2_score;

    int checks = 0;
    int errors = 0;

    rps_referee #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .p1_btn     (p1_btn),
        .p2_btn     (p2_btn),
        .result     (result),
        .p1_locked  (p1_locked),
        .p2_locked  (p2_locked),
        .round_done (round_done),
        .p1_score   (p1_score),
        .p2_score   (p2_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- round-level model ----------------
    // Choices as integers: 0 rock, 1 paper, 2 scissors; -1 means not chosen.
    bit         m_wait_release;
    int         m_c1;
    int         m_c2;
    int         m_show;      // result cycles still to display
    logic [2:0] m_res;
    bit         m_done;
    int         m_s1;
    int         m_s2;

    function automatic int choice_of(input logic [2:0] b);
        case (b)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        int d;
        if (reset) begin
            m_wait_release = 1; m_c1 = -1; m_c2 = -1; m_show = 0;
            m_done = 0; m_res = 3'b100; m_s1 = 0; m_s2 = 0;
        end else begin
            m_done = 0;
            if (m_show > 0) begin
                m_show--;
                if (m_show == 0) begin
                    m_wait_release = 1; m_c1 = -1; m_c2 = -1;
                end
            end else if (m_wait_release) begin
                if (p1_btn == 3'b000 && p2_btn == 3'b000) m_wait_release = 0;
            end else if (m_c1 >= 0 && m_c2 >= 0) begin
                d = (m_c1 - m_c2 + 3) % 3;
                m_res  = (d == 0) ? 3'b010 : (d == 1) ? 3'b000 : 3'b001;
                if (d == 1 && m_s1 < 9) m_s1++;
                if (d == 2 && m_s2 < 9) m_s2++;
                m_show = HOLD;
                m_done = 1;
            end else begin
                if (m_c1 < 0) m_c1 = choice_of(p1_btn);
                if (m_c2 < 0) m_c2 = choice_of(p2_btn);
            end
        end
    endtask

    // Compare process: update model on each edge, check DUT 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("m_result",     {1'b0, result},       {1'b0, (m_show > 0) ? m_res : 3'b100});
            chk("m_p1_locked",  {3'b0, p1_locked},    {3'b0, m_c1 >= 0});
            chk("m_p2_locked",  {3'b0, p2_locked},    {3'b0, m_c2 >= 0});
            chk("m_round_done", {3'b0, round_done},   {3'b0, m_done});
`ifdef RPS_SCORE_EN
            chk("m_p1_score",   p1_score, 4'(m_s1));
            chk("m_p2_score",   p2_score, 4'(m_s2));
`else
            chk("m_p1_score",   p1_score, 4'd0);
            chk("m_p2_score",   p2_score, 4'd0);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From REARM with buttons released: one full round ending back in REARM.
    task automatic play(input logic [2:0] b1, input logic [2:0] b2);
        step(1);                 // REARM -> COLLECT
        p1_btn = b1; p2_btn = b2;
        step(1);                 // capture both
        p1_btn = 3'b000; p2_btn = 3'b000;
        step(1);                 // result loaded
        step(HOLD);              // back to REARM
    endtask

    initial begin
        reset  = 1'b1;
        p1_btn = 3'b100;
        p2_btn = 3'b000;

        // 1: button held through reset never counts
        step(2);
        chk("rst_result", {1'b0, result}, 4'b0100);
        chk("rst_p1_locked", {3'b0, p1_locked}, 4'd0);
        chk("rst_round_done", {3'b0, round_done}, 4'd0);
        chk("rst_p1_score", p1_score, 4'd0);
        reset = 1'b0;
        step(3);
        chk("held_no_lock", {3'b0, p1_locked}, 4'd0);
        p1_btn = 3'b000;
        step(1);
        p1_btn = 3'b100;
        step(1);
        chk("t1_p1_lock", {3'b0, p1_locked}, 4'd1);

        // 2: rock vs scissors -> player 1
        p2_btn = 3'b001;
        step(1);
        chk("t2_p2_lock", {3'b0, p2_locked}, 4'd1);
        chk("t2_not_yet", {1'b0, result}, 4'b0100);
        step(1);
        chk("t2_result", {1'b0, result}, 4'b0000);
        chk("t2_done", {3'b0, round_done}, 4'd1);
        p1_btn = 3'b000; p2_btn = 3'b000;
        step(1);
        chk("t2_done_pulse", {3'b0, round_done}, 4'd0);
        step(6);
        chk("t2_last_hold", {1'b0, result}, 4'b0000);
        step(1);
        chk("t2_rearm", {1'b0, result}, 4'b0100);
        chk("t2_unlock", {2'b0, p1_locked, p2_locked}, 4'd0);

        // 3: simultaneous paper -> draw
        step(1);
        p1_btn = 3'b010; p2_btn = 3'b010;
        step(1);
        chk("t3_both_lock", {2'b0, p1_locked, p2_locked}, 4'b0011);
        step(1);
        chk("t3_draw", {1'b0, result}, 4'b0010);
        p1_btn = 3'b000; p2_btn = 3'b000;
        step(HOLD);

        // 4: change after lock ignored; held buttons block re-arm
        step(1);
        p1_btn = 3'b010;
        step(1);
        p1_btn = 3'b001;
        step(1);
        p2_btn = 3'b001;
        step(1);
        step(1);
        chk("t4_p2_wins", {1'b0, result}, 4'b0001);
        step(HOLD + 3);
        chk("t4_held_rearm", {2'b0, p1_locked, p2_locked}, 4'd0);
        chk("t4_held_idle", {1'b0, result}, 4'b0100);
        p1_btn = 3'b000; p2_btn = 3'b000;
        step(1);

        // 5: multi-bit presses ignored; reset mid-RESULT
        p1_btn = 3'b110;
        step(1);
        p1_btn = 3'b111;
        step(1);
        chk("t5_multibit", {3'b0, p1_locked}, 4'd0);
        chk("t5_idle", {1'b0, result}, 4'b0100);
        p1_btn = 3'b100;
        step(1);
        p2_btn = 3'b010;
        step(1);
        step(1);
        chk("t5_paper_wins", {1'b0, result}, 4'b0001);
        step(2);
        reset = 1'b1;
        step(1);
        chk("t5_rst_result", {1'b0, result}, 4'b0100);
        chk("t5_rst_done", {3'b0, round_done}, 4'd0);
        chk("t5_rst_score", p2_score, 4'd0);
        reset = 1'b0;
        p1_btn = 3'b000; p2_btn = 3'b000;

        // 6: ten player-1 wins and a draw
        for (int i = 0; i < 10; i++) play(3'b100, 3'b001);
        play(3'b001, 3'b001);
`ifdef RPS_SCORE_EN
        chk("t6_p1_sat", p1_score, 4'd9);
`else
        chk("t6_p1_off", p1_score, 4'd0);
`endif
        chk("t6_p2", p2_score, 4'd0);
        reset = 1'b1;
        step(1);
        chk("t6_rst_p1", p1_score, 4'd0);
        chk("t6_rst_p2", p2_score, 4'd0);
        reset = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
